// File: rtl/chess_pkg.sv
// Shared definitions for the chess clock turn sequencer.
//   state_e : game state encoding, also driven out on STATE for display/debug
//   side_e  : which player's chain resumes after a pause
//   MOVE_W_DEF : default width of the completed-move counter
package chess_pkg;

  localparam int unsigned MOVE_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_A  = 3'd1,
    ST_RUN_B  = 3'd2,
    ST_PAUSED = 3'd3,
    ST_FLAG   = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge press detector for one synchronised button level.
//   CLK   : system clock
//   CLR_N : asynchronous active-low reset (clears the prev register)
//   LEVEL : synchronised button level
//   PRESS : high for the single cycle where LEVEL=1 and the previous sample was 0
module btn_edge (
  input  logic CLK,
  input  logic CLR_N,
  input  logic LEVEL,
  output logic PRESS
);

  logic prev_q;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= LEVEL;
    end
  end

  assign PRESS = LEVEL & ~prev_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock turn sequencer: owns the game state, gates the 1 Hz tick into
// the running player's counter chain, detects time-out and counts moves.
//   CLK, CLR_N           : clock, asynchronous active-low reset
//   TICK                 : one-cycle 1 Hz time-base pulse
//   BTN_A/B/PAUSE/RST    : synchronised button levels
//   ZERO_A, ZERO_B       : chain all-zero indications
//   CE_A, CE_B           : chain enables (running side)
//   TICK_A, TICK_B       : gated decrement pulses
//   LOAD                 : one-cycle reload pulse after a new-game press
//   PAUSED               : high while paused
//   FLAG_A, FLAG_B       : player ran out of time
//   STATE                : encoded state
//   MOVES                : completed moves, saturating
module chess_clock_ctrl
  import chess_pkg::*;
#(
  parameter int unsigned MOVE_W = MOVE_W_DEF
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              TICK,
  input  logic              BTN_A,
  input  logic              BTN_B,
  input  logic              BTN_PAUSE,
  input  logic              BTN_RST,
  input  logic              ZERO_A,
  input  logic              ZERO_B,
  output logic              CE_A,
  output logic              CE_B,
  output logic              TICK_A,
  output logic              TICK_B,
  output logic              LOAD,
  output logic              PAUSED,
  output logic              FLAG_A,
  output logic              FLAG_B,
  output logic [2:0]        STATE,
  output logic [MOVE_W-1:0] MOVES
);

  logic press_a, press_b, press_pause, press_rst;

  btn_edge u_edge_a     (.CLK(CLK), .CLR_N(CLR_N), .LEVEL(BTN_A),     .PRESS(press_a));
  btn_edge u_edge_b     (.CLK(CLK), .CLR_N(CLR_N), .LEVEL(BTN_B),     .PRESS(press_b));
  btn_edge u_edge_pause (.CLK(CLK), .CLR_N(CLR_N), .LEVEL(BTN_PAUSE), .PRESS(press_pause));
  btn_edge u_edge_rst   (.CLK(CLK), .CLR_N(CLR_N), .LEVEL(BTN_RST),   .PRESS(press_rst));

  state_e            state_q, state_d;
  side_e             side_q, side_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic              flag_a_q, flag_a_d;
  logic              flag_b_q, flag_b_d;
  logic              load_q, load_d;
  logic [MOVE_W-1:0] moves_inc;

  // Saturating increment: a switch at full count leaves the counter alone.
  assign moves_inc = (moves_q == '1) ? moves_q : moves_q + MOVE_W'(1);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      side_q   <= SIDE_A;
      moves_q  <= '0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      side_q   <= side_d;
      moves_q  <= moves_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      load_q   <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    moves_d  = moves_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    load_d   = 1'b0;

    if (press_rst) begin
      state_d  = ST_IDLE;
      moves_d  = '0;
      flag_a_d = 1'b0;
      flag_b_d = 1'b0;
      load_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Pressing your own button hands the clock to the opponent.
          if (press_a && !press_b) begin
            state_d = ST_RUN_B;
          end else if (press_b && !press_a) begin
            state_d = ST_RUN_A;
          end
        end
        ST_RUN_A: begin
          if (TICK && ZERO_A) begin
            state_d  = ST_FLAG;
            flag_a_d = 1'b1;
          end else if (press_pause) begin
            state_d = ST_PAUSED;
            side_d  = SIDE_A;
          end else if (press_a) begin
            state_d = ST_RUN_B;
            moves_d = moves_inc;
          end
        end
        ST_RUN_B: begin
          if (TICK && ZERO_B) begin
            state_d  = ST_FLAG;
            flag_b_d = 1'b1;
          end else if (press_pause) begin
            state_d = ST_PAUSED;
            side_d  = SIDE_B;
          end else if (press_b) begin
            state_d = ST_RUN_A;
            moves_d = moves_inc;
          end
        end
        ST_PAUSED: begin
          if (press_pause) begin
            state_d = (side_q == SIDE_A) ? ST_RUN_A : ST_RUN_B;
          end
        end
        ST_FLAG: begin
          state_d = ST_FLAG;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign CE_A   = (state_q == ST_RUN_A);
  assign CE_B   = (state_q == ST_RUN_B);
  // The tick that causes time-out is withheld so the chain holds 0:00.
  assign TICK_A = TICK & CE_A & ~ZERO_A;
  assign TICK_B = TICK & CE_B & ~ZERO_B;
  assign PAUSED = (state_q == ST_PAUSED);
  assign LOAD   = load_q;
  assign FLAG_A = flag_a_q;
  assign FLAG_B = flag_b_q;
  assign STATE  = state_q;
  assign MOVES  = moves_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
module tb_chess_clock_ctrl;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       TICK = 1'b0;
  logic       BTN_A = 1'b0, BTN_B = 1'b0, BTN_PAUSE = 1'b0, BTN_RST = 1'b0;
  logic       ZERO_A = 1'b0, ZERO_B = 1'b0;
  logic       CE_A, CE_B, TICK_A, TICK_B, LOAD, PAUSED, FLAG_A, FLAG_B;
  logic [2:0] STATE;
  logic [7:0] MOVES;
  logic       s_ce_a, s_ce_b, s_tick_a, s_tick_b, s_load, s_paused, s_flag_a, s_flag_b;
  logic [2:0] s_state;
  logic [1:0] s_moves;

  int checks = 0;
  int failures = 0;

  chess_clock_ctrl #(.MOVE_W(8)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .TICK(TICK),
    .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_PAUSE(BTN_PAUSE), .BTN_RST(BTN_RST),
    .ZERO_A(ZERO_A), .ZERO_B(ZERO_B),
    .CE_A(CE_A), .CE_B(CE_B), .TICK_A(TICK_A), .TICK_B(TICK_B),
    .LOAD(LOAD), .PAUSED(PAUSED), .FLAG_A(FLAG_A), .FLAG_B(FLAG_B),
    .STATE(STATE), .MOVES(MOVES)
  );

  chess_clock_ctrl #(.MOVE_W(2)) dut_sat (
    .CLK(CLK), .CLR_N(CLR_N), .TICK(TICK),
    .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_PAUSE(BTN_PAUSE), .BTN_RST(BTN_RST),
    .ZERO_A(ZERO_A), .ZERO_B(ZERO_B),
    .CE_A(s_ce_a), .CE_B(s_ce_b), .TICK_A(s_tick_a), .TICK_B(s_tick_b),
    .LOAD(s_load), .PAUSED(s_paused), .FLAG_A(s_flag_a), .FLAG_B(s_flag_b),
    .STATE(s_state), .MOVES(s_moves)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; registered results are
  // observed there too, combinational outputs at the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    step();
    checks++; if (STATE !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", STATE); end
    checks++; if (MOVES !== 8'd0) begin failures++; $display("FAIL reset_moves got=%0d exp=0", MOVES); end
    checks++; if (LOAD !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", LOAD); end
    checks++; if ({CE_A, CE_B, PAUSED, FLAG_A, FLAG_B} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {CE_A, CE_B, PAUSED, FLAG_A, FLAG_B}); end
    @(negedge CLK);
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_start_ticks();
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    checks++; if (STATE !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", STATE); end
    for (int i = 0; i < 3; i++) begin
      TICK = 1'b1;
      @(negedge CLK);
      checks++; if ({TICK_A, TICK_B} !== 2'b10) begin failures++; $display("FAIL run_a_tick%0d got=%b exp=10", i, {TICK_A, TICK_B}); end
      step();
      TICK = 1'b0;
      step();
    end
    checks++; if (MOVES !== 8'd0) begin failures++; $display("FAIL start_moves got=%0d exp=0", MOVES); end
  endtask

  task automatic test_switch();
    BTN_A = 1'b1;
    step();
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd2 || MOVES !== 8'd1) begin failures++; $display("FAIL switch1 got=%0d/%0d exp=2/1", STATE, MOVES); end
    step();
    BTN_A = 1'b1;
    step();
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd2 || MOVES !== 8'd1) begin failures++; $display("FAIL wrong_side_press got=%0d/%0d exp=2/1", STATE, MOVES); end
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    checks++; if (STATE !== 3'd1 || MOVES !== 8'd2) begin failures++; $display("FAIL switch2 got=%0d/%0d exp=1/2", STATE, MOVES); end
    step();
  endtask

  task automatic test_pause();
    BTN_A = 1'b1;
    step();
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd2 || MOVES !== 8'd3) begin failures++; $display("FAIL switch3 got=%0d/%0d exp=2/3", STATE, MOVES); end
    BTN_PAUSE = 1'b1;
    step();
    BTN_PAUSE = 1'b0;
    checks++; if (STATE !== 3'd3 || PAUSED !== 1'b1) begin failures++; $display("FAIL pause_enter got=%0d/%b exp=3/1", STATE, PAUSED); end
    for (int i = 0; i < 5; i++) begin
      TICK = 1'b1;
      @(negedge CLK);
      checks++; if ({TICK_A, TICK_B} !== 2'b00) begin failures++; $display("FAIL paused_tick%0d got=%b exp=00", i, {TICK_A, TICK_B}); end
      step();
      TICK = 1'b0;
    end
    BTN_A = 1'b1;
    step();
    BTN_A = 1'b0;
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    checks++; if (STATE !== 3'd3 || MOVES !== 8'd3) begin failures++; $display("FAIL paused_presses got=%0d/%0d exp=3/3", STATE, MOVES); end
    BTN_PAUSE = 1'b1;
    step();
    BTN_PAUSE = 1'b0;
    checks++; if (STATE !== 3'd2 || PAUSED !== 1'b0) begin failures++; $display("FAIL resume got=%0d/%b exp=2/0", STATE, PAUSED); end
    step();
  endtask

  task automatic test_tick_and_press();
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    checks++; if (STATE !== 3'd1 || MOVES !== 8'd4) begin failures++; $display("FAIL switch4 got=%0d/%0d exp=1/4", STATE, MOVES); end
    TICK = 1'b1;
    BTN_A = 1'b1;
    @(negedge CLK);
    checks++; if (TICK_A !== 1'b1) begin failures++; $display("FAIL tick_with_press got=%b exp=1", TICK_A); end
    step();
    TICK = 1'b0;
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd2 || MOVES !== 8'd5) begin failures++; $display("FAIL press_after_tick got=%0d/%0d exp=2/5", STATE, MOVES); end
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    ZERO_A = 1'b1;
    TICK = 1'b1;
    BTN_A = 1'b1;
    @(negedge CLK);
    checks++; if (TICK_A !== 1'b0) begin failures++; $display("FAIL flagging_tick got=%b exp=0", TICK_A); end
    step();
    TICK = 1'b0;
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd4 || FLAG_A !== 1'b1 || FLAG_B !== 1'b0) begin failures++; $display("FAIL timeout got=%0d/%b%b exp=4/10", STATE, FLAG_A, FLAG_B); end
    checks++; if (MOVES !== 8'd6 || CE_A !== 1'b0) begin failures++; $display("FAIL timeout_moves got=%0d/%b exp=6/0", MOVES, CE_A); end
    ZERO_A = 1'b0;
    BTN_A = 1'b1;
    step();
    BTN_A = 1'b0;
    BTN_B = 1'b1;
    step();
    BTN_B = 1'b0;
    BTN_PAUSE = 1'b1;
    step();
    BTN_PAUSE = 1'b0;
    checks++; if (STATE !== 3'd4 || FLAG_A !== 1'b1) begin failures++; $display("FAIL flag_terminal got=%0d/%b exp=4/1", STATE, FLAG_A); end
    step();
  endtask

  task automatic test_rst_press();
    BTN_RST = 1'b1;
    @(negedge CLK);
    checks++; if (LOAD !== 1'b0) begin failures++; $display("FAIL load_early got=%b exp=0", LOAD); end
    step();
    BTN_RST = 1'b0;
    checks++; if (STATE !== 3'd0 || FLAG_A !== 1'b0 || MOVES !== 8'd0) begin failures++; $display("FAIL new_game got=%0d/%b/%0d exp=0/0/0", STATE, FLAG_A, MOVES); end
    checks++; if (LOAD !== 1'b1) begin failures++; $display("FAIL load_pulse got=%b exp=1", LOAD); end
    step();
    checks++; if (LOAD !== 1'b0) begin failures++; $display("FAIL load_width got=%b exp=0", LOAD); end
  endtask

  task automatic test_both_idle();
    BTN_A = 1'b1;
    BTN_B = 1'b1;
    step();
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    checks++; if (STATE !== 3'd0) begin failures++; $display("FAIL both_idle got=%0d exp=0", STATE); end
    step();
  endtask

  task automatic test_hold();
    BTN_B = 1'b1;
    step();
    checks++; if (STATE !== 3'd1) begin failures++; $display("FAIL hold_start got=%0d exp=1", STATE); end
    for (int i = 0; i < 9; i++) step();
    BTN_B = 1'b0;
    BTN_A = 1'b1;
    for (int i = 0; i < 10; i++) step();
    BTN_A = 1'b0;
    checks++; if (STATE !== 3'd2 || MOVES !== 8'd1) begin failures++; $display("FAIL hold_single got=%0d/%0d exp=2/1", STATE, MOVES); end
    step();
  endtask

  task automatic test_async_reset();
    #2;
    CLR_N = 1'b0;
    #1;
    checks++; if (STATE !== 3'd0 || MOVES !== 8'd0 || LOAD !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%0d/%b exp=0/0/0", STATE, MOVES, LOAD); end
    @(negedge CLK);
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    BTN_B = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      BTN_A = (i % 2 == 0);
      BTN_B = (i % 2 == 1);
      step();
      if (i == 2) begin
        checks++; if (s_moves !== 2'd3) begin failures++; $display("FAIL sat_reach got=%0d exp=3", s_moves); end
      end
    end
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    checks++; if (s_moves !== 2'd3 || s_state !== 3'd1) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=3/1", s_moves, s_state); end
    checks++; if (MOVES !== 8'd4 || STATE !== 3'd1) begin failures++; $display("FAIL wide_moves got=%0d/%0d exp=4/1", MOVES, STATE); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start_ticks();
    test_switch();
    test_pause();
    test_tick_and_press();
    test_timeout();
    test_rst_press();
    test_both_idle();
    test_hold();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
